seq_alu_core: RTL

//   Parametrised, multi-cycle successor to the combinational 16-bit ALU. One shared result bus

---
 rtl/seq_alu_pkg.sv | 25 ++
 rtl/seq_alu_muldiv.sv | 100 ++++++++++
 rtl/seq_alu_core.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (OP_ADD..OP_DIV); codes 101-111 are illegal
//   - controller state encoding
//   - bit positions of the flags inside the packed flag register
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int FLAG_C    = 0;
    localparam int FLAG_V    = 1;
    localparam int FLAG_DZ   = 2;
    localparam int FLAG_ILL  = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned multiply (shift-add) / divide (restoring).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin WIDTH iterations
//   is_div     : 1 = divide a/b, 0 = multiply a*b (sampled with start)
//   a, b       : operands (multiplier/dividend, multiplicand/divisor)
//   last       : high during the final iteration cycle (done pulse)
//   nxt_lo     : product low half / quotient after the current iteration
//   nxt_hi     : product high half / remainder after the current iteration
// nxt_lo/nxt_hi are the iteration outputs before they are clocked, so the
// controller can capture the finished result on the same edge as the last step.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] nxt_lo,
    output logic [WIDTH-1:0] nxt_hi
);

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] hi_r;     // accumulator high half / partial remainder
    logic [WIDTH-1:0] lo_r;     // multiplier bits / dividend bits -> quotient
    logic [WIDTH-1:0] opnd_r;   // multiplicand / divisor
    logic [SHW-1:0]   cnt_r;
    logic             is_div_r;
    logic             busy_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;

    assign last = busy_r & (cnt_r == {SHW{1'b0}});

    // One shift-add or restore-subtract step on the current register contents.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r};
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        nxt_lo      = lo_r;
        nxt_hi      = hi_r;
        if (is_div_r) begin
            // Remainder stays below the divisor, so bit WIDTH of the
            // difference is set exactly when the trial subtract underflows.
            if (!div_diff_s[WIDTH]) begin
                nxt_hi = div_diff_s[WIDTH-1:0];
                nxt_lo = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_shift_s[WIDTH-1:0];
                nxt_lo = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (lo_r[0]) begin
                mul_sum_s = {1'b0, hi_r} + {1'b0, opnd_r};
            end else begin
                mul_sum_s = {1'b0, hi_r};
            end
            nxt_hi = mul_sum_s[WIDTH:1];
            nxt_lo = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Operand load on start, then one iteration per cycle until the count expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            cnt_r    <= {SHW{1'b0}};
            is_div_r <= 1'b0;
            busy_r   <= 1'b0;
        end else if (start) begin
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= a;
            opnd_r   <= b;
            cnt_r    <= SHW'(WIDTH - 1);
            is_div_r <= is_div;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            hi_r <= nxt_hi;
            lo_r <= nxt_lo;
            if (cnt_r == {SHW{1'b0}}) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu_core.sv
// seq_alu_core: multi-cycle ALU with valid/ready handshakes on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only while idle)
//   op, a, b, cin       : opcode, operands, carry-in (add only)
//   out_valid/out_ready : result handshake; result held until accepted
//   res_lo, res_hi      : shared result bus
//   flag_c, flag_v, flag_dz, flag_ill : status flags, updated with the result
// Add/sub/shift/illegal and divide-by-zero finish on the accept edge;
// mul and div run WIDTH iterations in seq_alu_muldiv.
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz,
    output logic             flag_ill
);

    state_t                 state_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [WIDTH-1:0]       res_lo_r;
    logic [WIDTH-1:0]       res_hi_r;
    logic [NUM_FLAGS-1:0]   flags_r;

    logic                   accept_s;
    logic                   b_zero_s;
    logic                   iter_s;
    logic                   start_s;
    logic                   shift_ok_s;
    logic [WIDTH:0]         add_sum_s;
    logic [WIDTH-1:0]       sub_diff_s;
    logic [WIDTH-1:0]       sc_lo_s;
    logic [WIDTH-1:0]       sc_hi_s;
    logic [NUM_FLAGS-1:0]   sc_flags_s;
    logic                   md_last_s;
    logic [WIDTH-1:0]       md_lo_s;
    logic [WIDTH-1:0]       md_hi_s;

    assign accept_s   = in_valid & in_ready_r;
    assign b_zero_s   = (b == {WIDTH{1'b0}});
    assign iter_s     = (op == OP_MUL) | ((op == OP_DIV) & ~b_zero_s);
    assign start_s    = accept_s & iter_s;
    // WIDTH is a power of two, so b < WIDTH means no bits above the amount field.
    assign shift_ok_s = (b[WIDTH-1:SHW] == {(WIDTH-SHW){1'b0}});
    assign add_sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_diff_s = a - b;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign res_lo    = res_lo_r;
    assign res_hi    = res_hi_r;
    assign flag_c    = flags_r[FLAG_C];
    assign flag_v    = flags_r[FLAG_V];
    assign flag_dz   = flags_r[FLAG_DZ];
    assign flag_ill  = flags_r[FLAG_ILL];

    // Single-cycle results (add, sub, shift, divide-by-zero, illegal).
    always_comb begin
        sc_lo_s    = {WIDTH{1'b0}};
        sc_hi_s    = {WIDTH{1'b0}};
        sc_flags_s = {NUM_FLAGS{1'b0}};
        case (op)
            OP_ADD: begin
                sc_lo_s            = add_sum_s[WIDTH-1:0];
                sc_flags_s[FLAG_C] = add_sum_s[WIDTH];
                sc_flags_s[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) &
                                     (add_sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo_s            = sub_diff_s;
                sc_flags_s[FLAG_C] = (a < b);
                sc_flags_s[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) &
                                     (sub_diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHIFT: begin
                if (shift_ok_s) begin
                    sc_lo_s = a << b[SHW-1:0];
                    sc_hi_s = a >> b[SHW-1:0];
                end else begin
                    sc_lo_s = {WIDTH{1'b0}};
                    sc_hi_s = {WIDTH{1'b0}};
                end
            end
            OP_DIV: begin
                // Only selected when b == 0; nonzero divisors iterate.
                sc_lo_s             = {WIDTH{1'b1}};
                sc_hi_s             = a;
                sc_flags_s[FLAG_DZ] = 1'b1;
            end
            OP_MUL: begin
                sc_lo_s = {WIDTH{1'b0}};
            end
            default: begin
                sc_flags_s[FLAG_ILL] = 1'b1;
            end
        endcase
    end

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_s),
        .is_div (op == OP_DIV),
        .a      (a),
        .b      (b),
        .last   (md_last_s),
        .nxt_lo (md_lo_s),
        .nxt_hi (md_hi_s)
    );

    // Control FSM with handshake and result/flag output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            res_lo_r    <= {WIDTH{1'b0}};
            res_hi_r    <= {WIDTH{1'b0}};
            flags_r     <= {NUM_FLAGS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if (iter_s) begin
                            state_r <= ST_EXEC;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            res_lo_r    <= sc_lo_s;
                            res_hi_r    <= sc_hi_s;
                            flags_r     <= sc_flags_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (md_last_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        res_lo_r    <= md_lo_s;
                        res_hi_r    <= md_hi_s;
                        flags_r     <= {NUM_FLAGS{1'b0}};
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule
